// File: rtl/button_event_decoder.sv
// button_event_decoder: turns a debounced button level into short/double/long/repeat event pulses
// Ports: clk, rst (sync, active-high); btn_level (1 = pressed), enable (0 forces IDLE);
// short_press/double_press/long_press/repeat_pulse are one-cycle pulses; long_held and busy are levels.
module button_event_decoder #(
  parameter int LONG_PRESS_CYCLES = 1000,
  parameter int DOUBLE_GAP_CYCLES = 300,
  parameter int REPEAT_CYCLES     = 200,
  parameter int CNT_W             = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic btn_level,
  input  logic enable,
  output logic short_press,
  output logic double_press,
  output logic long_press,
  output logic repeat_pulse,
  output logic long_held,
  output logic busy
);
  typedef enum logic [2:0] {IDLE, PRESS1, WAIT2, PRESS2, LONG} state_e;
  // thresholds minus one: a hit on cnt_q means the current edge is the N-th sample
  localparam logic [CNT_W-1:0] LP_LAST  = CNT_W'(LONG_PRESS_CYCLES - 1);
  localparam logic [CNT_W-1:0] GAP_LAST = CNT_W'(DOUBLE_GAP_CYCLES - 1);
  localparam logic [CNT_W-1:0] REP_LAST = CNT_W'(REPEAT_CYCLES - 1);
  localparam logic [CNT_W-1:0] ONE      = CNT_W'(1);
  state_e state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d, cnt_inc;
  logic short_q, short_d, double_q, double_d, long_q, long_d, rep_q, rep_d, held_q, busy_q;
  assign short_press  = short_q;
  assign double_press = double_q;
  assign long_press   = long_q;
  assign repeat_pulse = rep_q;
  assign long_held    = held_q;
  assign busy         = busy_q;
  always_comb begin
    cnt_inc  = &cnt_q ? cnt_q : cnt_q + ONE;
    state_d  = state_q;
    cnt_d    = cnt_q;
    short_d  = 1'b0;
    double_d = 1'b0;
    long_d   = 1'b0;
    rep_d    = 1'b0;
    if (!enable) begin
      state_d = IDLE;
      cnt_d   = '0;
    end else begin
      case (state_q)
        IDLE: begin
          state_d = btn_level ? PRESS1 : IDLE;
          cnt_d   = btn_level ? ONE : '0;
        end
        PRESS1, PRESS2: begin
          if (!btn_level) begin
            state_d  = state_q == PRESS1 ? WAIT2 : IDLE;
            cnt_d    = state_q == PRESS1 ? ONE : '0;
            double_d = state_q == PRESS2;
          end else if (cnt_q == LP_LAST) begin
            state_d = LONG;
            cnt_d   = '0;
            long_d  = 1'b1;
          end else begin
            cnt_d = cnt_inc;
          end
        end
        WAIT2: begin
          if (btn_level) begin
            state_d = PRESS2;
            cnt_d   = ONE;
          end else if (cnt_q == GAP_LAST) begin
            state_d = IDLE;
            cnt_d   = '0;
            short_d = 1'b1;
          end else begin
            cnt_d = cnt_inc;
          end
        end
        LONG: begin
          state_d = btn_level ? LONG : IDLE;
          rep_d   = btn_level && cnt_q == REP_LAST;
          cnt_d   = (!btn_level || cnt_q == REP_LAST) ? '0 : cnt_inc;
        end
        default: begin
          state_d = IDLE;
          cnt_d   = '0;
        end
      endcase
    end
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      short_q  <= 1'b0;
      double_q <= 1'b0;
      long_q   <= 1'b0;
      rep_q    <= 1'b0;
      held_q   <= 1'b0;
      busy_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      short_q  <= short_d;
      double_q <= double_d;
      long_q   <= long_d;
      rep_q    <= rep_d;
      held_q   <= state_d == LONG;
      busy_q   <= state_d != IDLE;
    end
  end
endmodule

// File: tb/tb_button_event_decoder.sv
// tb_button_event_decoder: random and directed checks of button_event_decoder against a run-length model
module tb_button_event_decoder;
  localparam int LP  = 10;
  localparam int GP  = 5;
  localparam int RP  = 4;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic btn = 1'b0;
  logic en  = 1'b1;
  logic short_press, double_press, long_press, repeat_pulse, long_held, busy;
  int tests = 0;
  int fails = 0;
  int samp  = 0;
  bit chk_on = 1'b0;
  int n_short = 0, n_double = 0, n_long = 0, n_rep = 0;
  int short_at = 0, double_at = 0, long_at = 0, rep_at = 0;
  typedef struct {
    bit active;
    bit islong;
    int npress;
    int hrun;
    int lrun;
    bit s, d, l, r;
  } m_t;
  m_t m = '{default: 0};
  button_event_decoder #(
    .LONG_PRESS_CYCLES(LP), .DOUBLE_GAP_CYCLES(GP), .REPEAT_CYCLES(RP), .CNT_W(16)
  ) dut (
    .clk(clk), .rst(rst), .btn_level(btn), .enable(en),
    .short_press(short_press), .double_press(double_press), .long_press(long_press),
    .repeat_pulse(repeat_pulse), .long_held(long_held), .busy(busy)
  );
  always #5 clk = ~clk;
  // gesture model in terms of run lengths: highs in the current press, lows since release
  function automatic m_t step(input m_t c, input logic r, input logic e, input logic b);
    m_t n = c;
    n.s = 0; n.d = 0; n.l = 0; n.r = 0;
    if (r || !e) begin
      n.active = 0;
      n.islong = 0;
    end else if (b) begin
      if (!n.active) begin
        n.active = 1; n.islong = 0; n.npress = 1; n.hrun = 1; n.lrun = 0;
      end else if (n.lrun > 0) begin
        n.npress = 2; n.hrun = 1; n.lrun = 0;
      end else begin
        n.hrun++;
      end
      if (!n.islong && n.hrun == LP) begin
        n.l = 1;
        n.islong = 1;
      end else if (n.islong && (n.hrun - LP) % RP == 0) begin
        n.r = 1;
      end
    end else if (n.active) begin
      if (n.islong || n.npress == 2) begin
        n.d = !n.islong;
        n.active = 0;
        n.islong = 0;
      end else begin
        n.lrun++;
        if (n.lrun == GP) begin
          n.s = 1;
          n.active = 0;
        end
      end
    end
    return n;
  endfunction
  always @(posedge clk) begin
    m    <= step(m, rst, en, btn);
    samp <= samp + 1;
  end
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d at sample %0d", nm, act, exp, samp);
    end
  endtask
  always @(negedge clk) begin
    if (chk_on) begin
      chk("short_press", 32'(short_press), 32'(m.s));
      chk("double_press", 32'(double_press), 32'(m.d));
      chk("long_press", 32'(long_press), 32'(m.l));
      chk("repeat_pulse", 32'(repeat_pulse), 32'(m.r));
      chk("long_held", 32'(long_held), 32'(m.active && m.islong));
      chk("busy", 32'(busy), 32'(m.active));
      if (short_press)  begin n_short++;  short_at  = samp; end
      if (double_press) begin n_double++; double_at = samp; end
      if (long_press)   begin n_long++;   long_at   = samp; end
      if (repeat_pulse) begin n_rep++;    rep_at    = samp; end
    end
  end
  task automatic drv(input logic b, input int n);
    repeat (n) begin
      btn = b;
      @(negedge clk);
    end
  endtask
  int s0, cs, cd, cl, cr;
  task automatic mark();
    s0 = samp; cs = n_short; cd = n_double; cl = n_long; cr = n_rep;
  endtask
  initial begin
    @(negedge clk);
    chk_on = 1'b1;
    drv(0, 2);
    #1;
    chk("rst_busy", 32'(busy), 0);
    chk("rst_long_held", 32'(long_held), 0);
    rst = 1'b0;
    drv(0, 3);
    // short press
    mark(); drv(1, 3); drv(0, 8); #1;
    chk("t1_short_at", short_at - s0, 8);
    chk("t1_n_short", n_short - cs, 1);
    chk("t1_n_other", (n_double - cd) + (n_long - cl) + (n_rep - cr), 0);
    // double press
    mark(); drv(1, 3); drv(0, 2); drv(1, 3); drv(0, 8); #1;
    chk("t2_double_at", double_at - s0, 9);
    chk("t2_n_short", n_short - cs, 0);
    // long hold with repeats
    mark(); drv(1, 20); #1;
    chk("t3_long_held", 32'(long_held), 1);
    drv(0, 6); #1;
    chk("t3_long_at", long_at - s0, 10);
    chk("t3_n_rep", n_rep - cr, 2);
    chk("t3_rep_at", rep_at - s0, 18);
    chk("t3_n_sd", (n_short - cs) + (n_double - cd), 0);
    // long threshold boundary
    mark(); drv(1, 9); drv(0, 7); #1;
    chk("t4a_short_at", short_at - s0, 14);
    chk("t4a_n_long", n_long - cl, 0);
    mark(); drv(1, 10); drv(0, 7); #1;
    chk("t4b_long_at", long_at - s0, 10);
    chk("t4b_n_short", n_short - cs, 0);
    // gap boundary
    mark(); drv(1, 2); drv(0, 4); drv(1, 2); drv(0, 7); #1;
    chk("t5a_double_at", double_at - s0, 9);
    chk("t5a_n_short", n_short - cs, 0);
    mark(); drv(1, 2); drv(0, 5); drv(1, 2); drv(0, 7); #1;
    chk("t5b_n_short", n_short - cs, 2);
    chk("t5b_short_at", short_at - s0, 14);
    chk("t5b_n_double", n_double - cd, 0);
    // reset during long hold, button kept down
    mark(); drv(1, 14);
    rst = 1'b1; drv(1, 1); rst = 1'b0; #1;
    chk("t6_busy_after_rst", 32'(busy), 0);
    chk("t6_held_after_rst", 32'(long_held), 0);
    s0 = samp; drv(1, 12); drv(0, 8); #1;
    chk("t6_long_at", long_at - s0, 10);
    chk("t6_n_rep", n_rep - cr, 1);
    // enable drop during long hold
    mark(); drv(1, 14);
    en = 1'b0; drv(1, 1); en = 1'b1; #1;
    chk("t6b_busy_after_dis", 32'(busy), 0);
    s0 = samp; drv(1, 12); drv(0, 8); #1;
    chk("t6b_long_at", long_at - s0, 10);
    chk("t6b_n_rep", n_rep - cr, 1);
    // random gestures with occasional disable and reset
    for (int i = 0; i < 300; i++) begin
      logic b;
      int n;
      b   = 1'($urandom_range(0, 1));
      n   = $urandom_range(1, 25);
      en  = $urandom_range(0, 11) != 0;
      rst = $urandom_range(0, 39) == 0;
      btn = b;
      @(negedge clk);
      rst = 1'b0;
      drv(b, n - 1);
    end
    en = 1'b1;
    drv(0, 10);
    #1;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/button_event_decoder.md
Name: button_event_decoder

Overview:
- Consumer-side companion to the debouncer.
- Takes the clean, synchronized, debounced button level and decodes it into discrete user events: short press, double press, long press and auto-repeat while held.
- Sits between the debouncer output and control logic, so downstream blocks see one-cycle event pulses instead of raw levels.

Parameters:
- LONG_PRESS_CYCLES, 1000: consecutive high samples that make a press "long".
- DOUBLE_GAP_CYCLES, 300: consecutive low samples after a first release that close the double-press window.
- REPEAT_CYCLES, 200: high samples between repeat pulses once long press is reached.
- CNT_W, 16: counter width. All three cycle parameters are >= 2 and <= 2^CNT_W - 1.

Ports:
- clk  input  1  system clock, all logic on rising edge
- rst  input  1  synchronous reset, active-high
- btn_level  input  1  debounced button level, 1 = pressed; already synchronous to clk
- enable  input  1  decoder enable; 0 forces IDLE and suppresses all events
- short_press  output  1  one-cycle pulse: single press released and not followed by a second press
- double_press  output  1  one-cycle pulse: second press released inside the gap window
- long_press  output  1  one-cycle pulse: press held LONG_PRESS_CYCLES samples
- repeat_pulse  output  1  one-cycle pulse every REPEAT_CYCLES samples while in long hold
- long_held  output  1  level, high while in LONG state
- busy  output  1  level, high whenever state != IDLE

Behaviour:
- All outputs are registered. Reset value of every output is 0; state is IDLE; cnt is 0.
- Counting convention: "N-th sample" means the N-th consecutive rising edge at which btn_level holds the stated value. A pulse is high during the single cycle after the edge that detects the event.
- IDLE:
  - btn_level=1 & enable -> PRESS1, cnt=1. This edge is the 1st high sample.
- PRESS1:
  - btn_level=1: cnt++.
  - On the LONG_PRESS_CYCLES-th high sample -> LONG, cnt=0, long_press pulse.
  - btn_level=0 -> WAIT2, cnt=1. This edge is the 1st low sample.
- WAIT2:
  - btn_level=0: cnt++.
  - On the DOUBLE_GAP_CYCLES-th low sample -> IDLE, short_press pulse.
  - btn_level=1 before that -> PRESS2, cnt=1.
- PRESS2:
  - btn_level=0 -> IDLE, double_press pulse.
  - On the LONG_PRESS_CYCLES-th high sample -> LONG, long_press pulse, cnt=0. The double press is discarded.
- LONG:
  - btn_level=1: cnt++.
  - When cnt reaches REPEAT_CYCLES: repeat_pulse, cnt=0.
  - btn_level=0 -> IDLE with no pulse.
  - long_held is high in every cycle the state is LONG.
- Exactly one event pulse per cycle at most. short, double and long pulses are mutually exclusive per gesture.
- Boundaries:
  - LONG_PRESS_CYCLES-1 highs then release is short/double.
  - Exactly LONG_PRESS_CYCLES highs is long, even if released on the next edge.
  - A second press at low sample DOUBLE_GAP_CYCLES-1 is a double press.
  - A second press on the edge after short_press fires starts a fresh PRESS1.
- enable=0 in any state: next state is IDLE, cnt=0, no pulse emitted that cycle or for the abandoned gesture.
  - A button still held when enable returns is treated as a new press from the first sampled high.
- rst mid-gesture:
  - Same as enable=0, plus all outputs cleared on that edge.
  - If the button is held through reset release, counting starts at the first edge after rst deasserts.
- Counter saturates rather than wraps. It can never exceed the active threshold, given the parameter constraints.

Test Plan:
Bench parameters: LONG_PRESS_CYCLES=10, DOUBLE_GAP_CYCLES=5, REPEAT_CYCLES=4.
1. High 3 samples, then low -> short_press high exactly one cycle after the 5th low sample; double/long/repeat stay 0; busy drops the same cycle.
2. High 3, low 2, high 3, low -> double_press one cycle after the first low of the second release; no short_press ever.
3. High 20 samples -> long_press after the 10th high; repeat_pulse after the 14th and 18th highs; long_held high from the cycle after the 10th high until the cycle after the first low; no other pulses.
4. Boundary: 9 highs then release -> short_press only. 10 highs then release -> long_press only, no short.
5. Gap boundary: high 2, low 4, high 2, low -> double_press. High 2, low 5, high 2, low -> short_press, then a second short_press after 5 more lows.
6. Assert rst (or drop enable) at the 15th high of a long hold -> all outputs 0 from the next cycle, no repeat. Release with the button still held -> long_press 10 samples later.
